// File: rtl/uart_tx_fifo_pkg.sv
// Shared constants and state encoding for the UART transmit buffer/sequencer.
package uart_tx_fifo_pkg;

  localparam int BYTE_W           = 8;
  localparam int TIMER_W          = 16;
  localparam int DEF_GAP_CYC      = 20;
  localparam int DEF_BUSY_TIMEOUT = 15;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND      = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } tx_state_t;

endpackage

// File: rtl/uart_fifo_sync.sv
// Byte FIFO: array storage, wrapping pointers, a separate level counter and
// registered full/empty/overflow flags.
module uart_fifo_sync
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [BYTE_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       level,
  output logic              overflow
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW:0]       level_reg;
  logic [AW:0]       level_next;
  logic              full_reg;
  logic              empty_reg;
  logic              overflow_reg;
  logic [BYTE_W-1:0] rd_data_reg;
  logic              do_wr;
  logic              do_rd;

  // A write into a full FIFO is dropped even if a read frees a slot this cycle.
  assign do_wr = wr_en && !full_reg;
  assign do_rd = rd_en && !empty_reg;

  always_comb begin
    level_next = level_reg;
    if (do_wr && !do_rd)
      level_next = level_reg + 1'b1;
    else if (!do_wr && do_rd)
      level_next = level_reg - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_wr)
      mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      full_reg     <= 1'b0;
      empty_reg    <= 1'b1;
      overflow_reg <= 1'b0;
      rd_data_reg  <= '0;
    end else begin
      if (do_wr)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_rd) begin
        rd_ptr_reg  <= rd_ptr_reg + 1'b1;
        rd_data_reg <= mem[rd_ptr_reg];
      end
      level_reg    <= level_next;
      full_reg     <= (level_next == FULL_LVL);
      empty_reg    <= (level_next == '0);
      overflow_reg <= wr_en && full_reg;
    end
  end

  assign rd_data  = rd_data_reg;
  assign full     = full_reg;
  assign empty    = empty_reg;
  assign level    = level_reg;
  assign overflow = overflow_reg;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffers bytes and hands them to the UART transmitter one at a time, with a
// send pulse, busy-flag tracking, busy timeout and a stop-bit guard gap.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int AW           = 4,
  parameter int GAP_CYC      = DEF_GAP_CYC,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       level,
  output logic              overflow,
  output logic [BYTE_W-1:0] uart_data,
  output logic              uart_send_en,
  input  logic              tx_flag,
  output logic              busy,
  output logic              timeout_err,
  input  logic              clr_err
);

  localparam logic [TIMER_W-1:0] BUSY_LAST = TIMER_W'(BUSY_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD  = TIMER_W'(GAP_CYC - 1);

  tx_state_t          state_reg;
  logic [TIMER_W-1:0] timer_reg;
  logic               send_en_reg;
  logic               timeout_err_reg;
  logic               rd_en;

  // uart_data is the FIFO's read register: it only changes on a pop, so it
  // stays put for the whole frame the transmitter may be capturing.
  uart_fifo_sync #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_data  (uart_data),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow)
  );

  assign rd_en = (state_reg == ST_IDLE) && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      timer_reg       <= '0;
      send_en_reg     <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else begin
      send_en_reg <= 1'b0;
      // A timeout raised below in the same cycle overrides this clear.
      if (clr_err)
        timeout_err_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (!empty) begin
            send_en_reg <= 1'b1;
            state_reg   <= ST_SEND;
          end
        end
        ST_SEND: begin
          timer_reg <= '0;
          state_reg <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (tx_flag) begin
            state_reg <= ST_WAIT_DONE;
          end else if (timer_reg == BUSY_LAST) begin
            // Byte is abandoned; still guard the line before the next one.
            timeout_err_reg <= 1'b1;
            timer_reg       <= GAP_LOAD;
            state_reg       <= ST_GAP;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!tx_flag) begin
            timer_reg <= GAP_LOAD;
            state_reg <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (timer_reg == '0)
            state_reg <= ST_IDLE;
          else
            timer_reg <= timer_reg - 1'b1;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign uart_send_en = send_en_reg;
  assign timeout_err  = timeout_err_reg;
  assign busy         = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo: queue/timestamp reference model compared
// every cycle, a simple transmitter model, and literal spot checks.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int GAP   = 20;
  localparam int BTO   = 15;

  localparam int TX_NORMAL  = 0;
  localparam int TX_NO_RISE = 1;
  localparam int TX_HOLD    = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       tx_flag = 1'b0;
  logic       clr_err = 1'b0;
  logic       full, empty, overflow, uart_send_en, busy, timeout_err;
  logic [AW:0] level;
  logic [7:0] uart_data;

  uart_tx_fifo #(
    .DEPTH (DEPTH), .AW (AW), .GAP_CYC (GAP), .BUSY_TIMEOUT (BTO)
  ) dut (
    .clk (clk), .rst_n (rst_n), .wr_en (wr_en), .wr_data (wr_data),
    .full (full), .empty (empty), .level (level), .overflow (overflow),
    .uart_data (uart_data), .uart_send_en (uart_send_en), .tx_flag (tx_flag),
    .busy (busy), .timeout_err (timeout_err), .clr_err (clr_err)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] q[$];
  bit         m_active, m_got_busy, m_send, m_ovf, m_err;
  logic [7:0] m_data;
  int         m_send_edge, m_release_edge, edge_n;
  bit         full_pre, do_read, timeout_now;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q.delete();
      m_active = 0; m_got_busy = 0; m_send = 0; m_ovf = 0; m_err = 0;
      m_data = 8'h00; m_release_edge = -1; m_send_edge = 0;
    end else begin
      edge_n++;
      full_pre    = (q.size() == DEPTH);
      do_read     = !m_active && (q.size() != 0);
      timeout_now = 0;
      if (m_active) begin
        if (edge_n == m_send_edge + 1) begin
          // pulse cycle: transmitter flag not yet looked at
        end else if (m_release_edge >= 0) begin
          if (edge_n == m_release_edge) m_active = 0;
        end else if (!m_got_busy) begin
          if (tx_flag) m_got_busy = 1;
          else if (edge_n == m_send_edge + 1 + BTO) begin
            timeout_now = 1;
            m_release_edge = edge_n + GAP;
          end
        end else if (!tx_flag) begin
          m_release_edge = edge_n + GAP;
        end
      end
      if (timeout_now) m_err = 1;
      else if (clr_err) m_err = 0;
      m_send = do_read;
      if (do_read) begin
        m_data = q.pop_front();
        m_active = 1; m_send_edge = edge_n; m_got_busy = 0; m_release_edge = -1;
      end
      m_ovf = wr_en && full_pre;
      if (wr_en && !full_pre) q.push_back(wr_data);
    end
  end

  // ---------------- per-cycle compare + send log ----------------
  logic [7:0] sent_log[$];

  initial forever begin
    @(negedge clk);
    check("full",        full,         (q.size() == DEPTH));
    check("empty",       empty,        (q.size() == 0));
    check("level",       level,        q.size());
    check("overflow",    overflow,     m_ovf);
    check("uart_data",   uart_data,    m_data);
    check("send_en",     uart_send_en, m_send);
    check("busy",        busy,         m_active);
    check("timeout_err", timeout_err,  m_err);
    if (uart_send_en === 1'b1) begin
      sent_log.push_back(uart_data);
      $display("send byte 0x%02h level=%0d at %0t", uart_data, level, $time);
    end
  end

  // ---------------- transmitter model ----------------
  int tx_mode = TX_NORMAL;
  int tx_hold = 380;
  int tx_cnt  = 0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      tx_flag = 1'b0; tx_cnt = 0;
    end else if (tx_cnt == 0) begin
      if (uart_send_en === 1'b1) tx_cnt = 1;
    end else begin
      tx_cnt++;
      if (tx_mode == TX_NO_RISE) begin
        if (tx_cnt >= 4) tx_cnt = 0;
      end else if (tx_cnt == 4) begin
        tx_flag = 1'b1;
      end else if (tx_cnt >= 4 + tx_hold && tx_mode != TX_HOLD) begin
        tx_flag = 1'b0; tx_cnt = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_send(input string name);
    int k = 0;
    while (uart_send_en !== 1'b1 && k < 2000) begin step(); k++; end
    if (uart_send_en !== 1'b1) check(name, 0, 1);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (!(empty === 1'b1 && busy === 1'b0) && k < 5000) begin step(); k++; end
    check(name, (empty === 1'b1 && busy === 1'b0), 1);
  endtask

  logic [7:0] exp_q[$];
  int         k, pulses;
  bit         seen_ff;

  initial begin
    #1 rst_n = 1'b0;
    step(); step();
    check("rst_empty", empty, 1);
    check("rst_level", level, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    step();

    // Single byte: latency, then busy drop after the guard gap.
    wr_en = 1'b1; wr_data = 8'hA5;
    step();
    wr_en = 1'b0;
    check("lat_empty", empty, 0);
    check("lat_send0", uart_send_en, 0);
    step();
    check("lat_send1", uart_send_en, 1);
    check("lat_data", uart_data, 8'hA5);
    step();
    check("lat_send2", uart_send_en, 0);

    // Burst of 01..10 while the A5 frame is still in flight.
    for (int i = 1; i <= 16; i++) write_byte(8'(i));
    check("burst_full", full, 1);
    check("burst_level", level, 16);

    k = 0;
    while (tx_flag !== 1'b1 && k < 500) begin step(); k++; end
    while (tx_flag !== 1'b0 && k < 500) begin step(); k++; end
    check("tx_fall_seen", tx_flag, 0);
    tx_hold = 40;
    k = 0;
    while (busy !== 1'b0 && k < 100) begin step(); k++; end
    check("gap_busy_low", k, GAP + 1);
    wait_idle("burst_drain");
    check("burst_count", sent_log.size(), 17);
    if (sent_log.size() == 17) begin
      check("burst_first", sent_log[0], 8'hA5);
      for (int i = 1; i <= 16; i++) check("burst_order", sent_log[i], 8'(i));
    end

    // Overflow with the sequencer parked waiting for the busy flag to drop.
    sent_log.delete();
    tx_mode = TX_HOLD;
    write_byte(8'h20);
    wait_send("ovf_first_send");
    for (int i = 0; i < 16; i++) write_byte(8'h21 + 8'(i));
    check("ovf_full", full, 1);
    check("ovf_level", level, 16);
    write_byte(8'hFF);
    check("ovf_pulse", overflow, 1);
    check("ovf_level_hold", level, 16);
    step();
    check("ovf_pulse_end", overflow, 0);
    tx_mode = TX_NORMAL;
    wait_idle("ovf_drain");
    seen_ff = 0;
    foreach (sent_log[i]) if (sent_log[i] == 8'hFF) seen_ff = 1;
    check("ovf_ff_dropped", seen_ff, 0);
    check("ovf_count", sent_log.size(), 17);

    // Wrap: random bursts of 10 interleaved with draining.
    sent_log.delete();
    exp_q.delete();
    for (int b = 0; b < 4; b++) begin
      tx_hold = $urandom_range(5, 40);
      for (int i = 0; i < 10; i++) begin
        wr_data = 8'($urandom);
        exp_q.push_back(wr_data);
        write_byte(wr_data);
        repeat ($urandom_range(0, 2)) step();
      end
      wait_idle("wrap_drain");
    end
    check("wrap_count", sent_log.size(), 40);
    if (sent_log.size() == 40)
      foreach (exp_q[i]) check("wrap_order", sent_log[i], exp_q[i]);

    // Timeout: flag never rises for the first byte; second byte still goes.
    tx_hold = 30;
    tx_mode = TX_NO_RISE;
    write_byte(8'h77);
    write_byte(8'h78);
    wait_send("to_first_send");
    check("to_first_data", uart_data, 8'h77);
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 15) check("to_err_before", timeout_err, 0);
      if (i == 16) check("to_err_set", timeout_err, 1);
    end
    tx_mode = TX_NORMAL;
    wait_send("to_second_send");
    check("to_second_data", uart_data, 8'h78);
    wait_idle("to_drain");
    check("to_err_sticky", timeout_err, 1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("to_err_cleared", timeout_err, 0);

    // Reset in the middle of a frame with bytes queued.
    tx_mode = TX_HOLD;
    write_byte(8'h40);
    wait_send("rst_first_send");
    for (int i = 1; i <= 5; i++) write_byte(8'h40 + 8'(i));
    step(); step(); step();
    check("mid_level", level, 5);
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("arst_level", level, 0);
    check("arst_empty", empty, 1);
    check("arst_full", full, 0);
    check("arst_busy", busy, 0);
    check("arst_send", uart_send_en, 0);
    check("arst_data", uart_data, 8'h00);
    check("arst_ovf", overflow, 0);
    check("arst_err", timeout_err, 0);
    step(); step(); step();
    tx_mode = TX_NORMAL;
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (uart_send_en === 1'b1) pulses++;
    end
    check("post_rst_no_pulse", pulses, 0);
    write_byte(8'h55);
    wait_send("post_rst_send");
    check("post_rst_data", uart_data, 8'h55);
    wait_idle("final_drain");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
